// File: rtl/mcs_spi_loader.sv
// Per-card MCS image SPI engine: one 16-bit buffer word per SPI frame, in program or readback mode.
// Define MCS_SPI_CRC_EN to build the CRC-16/CCITT of transferred words; otherwise crc reads 16'h0000.
module mcs_spi_loader #(
  parameter int unsigned CLK_DIV   = 2,
  parameter logic [15:0] LAST_ADDR = 16'h0FFE,
  parameter logic [15:0] DONE_ADDR = 16'h0FFC
) (
  input  logic        clk_25m,
  input  logic        rst_n,
  input  logic [15:0] p2040_instruction,
  output logic [10:0] buf_rd_addr,
  input  logic [15:0] buf_rd_data,
  output logic        rb_wr_en,
  output logic [15:0] rb_wr_data,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [15:0] mcs_spi_addr,
  output logic [15:0] mcs_spi_addr_r0,
  output logic        busy,
  output logic [15:0] crc
);

  localparam int unsigned DIV_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  // state  | meaning
  // IDLE   | waiting for a rising edge of cmd_ok
  // FETCH  | buffer address presented, word latched at end of cycle
  // SHIFT  | cs_n low, 32 sclk phases (16 bits) of CLK_DIV cycles each
  // GAP    | cs_n high for CLK_DIV cycles, then step address or finish
  // DONE   | done signature held until cmd_ok drops
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             cmd_ok;
  logic             cmd_ok_q, cmd_ok_d;
  logic             abort;
  logic             mode_rb_q, mode_rb_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      addr_r0_q, addr_r0_d;
  logic [15:0]      tx_q, tx_d;
  logic [15:0]      rx_q, rx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       phase_q, phase_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             rb_wr_en_q, rb_wr_en_d;
  logic [15:0]      rb_wr_data_q, rb_wr_data_d;

`ifdef MCS_SPI_CRC_EN
  logic [15:0] word_q, word_d;
  logic [15:0] crc_q, crc_d;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [15:0] w);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      r = (r[15] ^ w[i]) ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction
`endif

  assign cmd_ok = (p2040_instruction == 16'h000F) || (p2040_instruction == 16'h00AA);
  assign busy   = (state_q == S_FETCH) || (state_q == S_SHIFT) || (state_q == S_GAP);
  assign abort  = busy && !cmd_ok;

  always_comb begin
    state_d      = state_q;
    cmd_ok_d     = cmd_ok;
    mode_rb_d    = mode_rb_q;
    addr_d       = addr_q;
    addr_r0_d    = addr_r0_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    div_d        = div_q;
    phase_d      = phase_q;
    cs_n_d       = cs_n_q;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    rb_wr_en_d   = 1'b0;
    rb_wr_data_d = rb_wr_data_q;
`ifdef MCS_SPI_CRC_EN
    word_d       = word_q;
    crc_d        = crc_q;
`endif

    if (abort) begin
      // Partial frame is dropped; no readback strobe survives an abort.
      state_d   = S_IDLE;
      cs_n_d    = 1'b1;
      sclk_d    = 1'b0;
      mosi_d    = 1'b0;
      addr_d    = '0;
      addr_r0_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_ok && !cmd_ok_q) begin
            state_d   = S_FETCH;
            mode_rb_d = (p2040_instruction == 16'h00AA);
            addr_d    = '0;
            addr_r0_d = '0;
`ifdef MCS_SPI_CRC_EN
            crc_d     = 16'hFFFF;
`endif
          end
        end

        S_FETCH: begin
          tx_d    = buf_rd_data;
          mosi_d  = mode_rb_q ? 1'b0 : buf_rd_data[15];
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          div_d   = DIV_LOAD;
          phase_d = 5'd31;
          state_d = S_SHIFT;
`ifdef MCS_SPI_CRC_EN
          word_d  = buf_rd_data;
`endif
        end

        S_SHIFT: begin
          if (div_q != '0) begin
            div_d = div_q - DIV_W'(1);
          end else begin
            div_d = DIV_LOAD;
            if (phase_q == 5'd0) begin
              sclk_d  = 1'b0;
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
              state_d = S_GAP;
`ifdef MCS_SPI_CRC_EN
              crc_d   = crc16_step(crc_q, mode_rb_q ? rx_q : word_q);
`endif
            end else begin
              phase_d = phase_q - 5'd1;
              if (!sclk_q) begin
                sclk_d = 1'b1;
                rx_d   = {rx_q[14:0], spi_miso};
                if (mode_rb_q && (phase_q == 5'd1)) begin
                  rb_wr_en_d   = 1'b1;
                  rb_wr_data_d = {rx_q[14:0], spi_miso};
                end
              end else begin
                sclk_d = 1'b0;
                tx_d   = {tx_q[14:0], 1'b0};
                mosi_d = mode_rb_q ? 1'b0 : tx_q[14];
              end
            end
          end
        end

        S_GAP: begin
          if (div_q != '0) begin
            div_d = div_q - DIV_W'(1);
          end else begin
            addr_r0_d = addr_q;
            if (addr_q == LAST_ADDR) begin
              addr_d  = DONE_ADDR;
              state_d = S_DONE;
            end else begin
              addr_d  = addr_q + 16'd2;
              state_d = S_FETCH;
            end
          end
        end

        S_DONE: begin
          if (!cmd_ok) begin
            addr_d    = '0;
            addr_r0_d = '0;
            state_d   = S_IDLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cmd_ok_q     <= 1'b0;
      mode_rb_q    <= 1'b0;
      addr_q       <= '0;
      addr_r0_q    <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      div_q        <= '0;
      phase_q      <= '0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      rb_wr_en_q   <= 1'b0;
      rb_wr_data_q <= '0;
`ifdef MCS_SPI_CRC_EN
      word_q       <= '0;
      crc_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cmd_ok_q     <= cmd_ok_d;
      mode_rb_q    <= mode_rb_d;
      addr_q       <= addr_d;
      addr_r0_q    <= addr_r0_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      div_q        <= div_d;
      phase_q      <= phase_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      rb_wr_en_q   <= rb_wr_en_d;
      rb_wr_data_q <= rb_wr_data_d;
`ifdef MCS_SPI_CRC_EN
      word_q       <= word_d;
      crc_q        <= crc_d;
`endif
    end
  end

  assign buf_rd_addr     = addr_q[11:1];
  assign mcs_spi_addr    = addr_q;
  assign mcs_spi_addr_r0 = addr_r0_q;
  assign spi_cs_n        = cs_n_q;
  assign spi_sclk        = sclk_q;
  assign spi_mosi        = mosi_q;
  assign rb_wr_en        = rb_wr_en_q;
  assign rb_wr_data      = rb_wr_data_q;
`ifdef MCS_SPI_CRC_EN
  assign crc             = crc_q;
`else
  assign crc             = 16'h0000;
`endif

endmodule

// File: tb/tb_mcs_spi_loader.sv
// Bench for mcs_spi_loader: SPI bus decoder, MISO slave model and frame scoreboard.
// Runs with a shortened image (LAST_ADDR 0x003E, 32 frames) to keep simulation short.
module tb_mcs_spi_loader;
  localparam int unsigned CLK_DIV   = 2;
  localparam logic [15:0] LAST_ADDR = 16'h003E;
  localparam logic [15:0] DONE_ADDR = 16'h0FFC;
  localparam int NFR        = 32;
  localparam int FRAME_CYC  = 1 + 33 * CLK_DIV;
  localparam int RUN_BUDGET = NFR * FRAME_CYC + 200;

  logic        clk_25m = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] p2040_instruction = 16'h0000;
  logic [10:0] buf_rd_addr;
  logic [15:0] buf_rd_data;
  logic        rb_wr_en;
  logic [15:0] rb_wr_data;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;
  logic [15:0] mcs_spi_addr;
  logic [15:0] mcs_spi_addr_r0;
  logic        busy;
  logic [15:0] crc;

  logic [15:0] mem [0:2047];
  assign buf_rd_data = mem[buf_rd_addr];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int miso_idx = 0;
  logic [15:0] frames[$];
  int          fr_start[$];
  logic [15:0] rb_data[$];
  logic [10:0] rb_addr[$];

  mcs_spi_loader #(
    .CLK_DIV(CLK_DIV),
    .LAST_ADDR(LAST_ADDR),
    .DONE_ADDR(DONE_ADDR)
  ) dut (
    .clk_25m(clk_25m),
    .rst_n(rst_n),
    .p2040_instruction(p2040_instruction),
    .buf_rd_addr(buf_rd_addr),
    .buf_rd_data(buf_rd_data),
    .rb_wr_en(rb_wr_en),
    .rb_wr_data(rb_wr_data),
    .spi_cs_n(spi_cs_n),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .mcs_spi_addr(mcs_spi_addr),
    .mcs_spi_addr_r0(mcs_spi_addr_r0),
    .busy(busy),
    .crc(crc)
  );

  always #20 clk_25m = ~clk_25m;

  initial forever begin
    @(posedge clk_25m);
    cyc++;
  end

  // Bus decoder plus mode-0 slave: MOSI captured on sclk rise, MISO shifted on sclk fall.
  initial begin : monitor
    logic pcs, psclk;
    logic [15:0] sh, miso_sr;
    int bitn;
    pcs = 1'b1; psclk = 1'b0; sh = '0; miso_sr = '0; bitn = 0;
    forever begin
      @(negedge clk_25m);
      if (pcs && !spi_cs_n) begin
        fr_start.push_back(cyc);
        bitn = 0;
        miso_sr = ~(16'(2 * miso_idx));
        miso_idx++;
        spi_miso = miso_sr[15];
      end
      if (!spi_cs_n && !psclk && spi_sclk) begin
        sh = {sh[14:0], spi_mosi};
        bitn++;
        if (bitn == 16) frames.push_back(sh);
      end
      if (!spi_cs_n && psclk && !spi_sclk) begin
        miso_sr = miso_sr << 1;
        spi_miso = miso_sr[15];
      end
      if (rb_wr_en) begin
        rb_data.push_back(rb_wr_data);
        rb_addr.push_back(buf_rd_addr);
      end
      pcs = spi_cs_n;
      psclk = spi_sclk;
    end
  end

`ifdef MCS_SPI_CRC_EN
  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [15:0] w);
    logic [15:0] r;
    logic [7:0]  bytes [2];
    r = c;
    bytes[0] = w[15:8];
    bytes[1] = w[7:0];
    for (int b = 0; b < 2; b++) begin
      r = r ^ {bytes[b], 8'h00};
      for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction
`endif

  task automatic start_run(input logic [15:0] ins);
    frames.delete(); fr_start.delete(); rb_data.delete(); rb_addr.delete();
    miso_idx = 0;
    @(posedge clk_25m); #1;
    p2040_instruction = ins;
  endtask

  task automatic stop_run();
    @(posedge clk_25m); #1;
    p2040_instruction = 16'h0000;
    repeat (3) @(negedge clk_25m);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < RUN_BUDGET; i++) begin
      @(negedge clk_25m);
      if (mcs_spi_addr == DONE_ADDR && mcs_spi_addr_r0 == LAST_ADDR) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    p2040_instruction = 16'h0000;
    repeat (3) @(negedge clk_25m);
    n_checks++;
    if ({spi_cs_n, spi_sclk, spi_mosi, rb_wr_en, busy} !== 5'b10000)
      $display("FAIL reset_ctrl: got %b expected 10000", {spi_cs_n, spi_sclk, spi_mosi, rb_wr_en, busy});
    else n_pass++;
    n_checks++;
    if (mcs_spi_addr !== 16'h0 || mcs_spi_addr_r0 !== 16'h0)
      $display("FAIL reset_addr: got %h/%h expected 0000/0000", mcs_spi_addr, mcs_spi_addr_r0);
    else n_pass++;
    n_checks++;
    if (buf_rd_addr !== 11'h0 || rb_wr_data !== 16'h0 || crc !== 16'h0)
      $display("FAIL reset_data: got %h/%h/%h expected 0", buf_rd_addr, rb_wr_data, crc);
    else n_pass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk_25m);
    n_checks++;
    if (busy !== 1'b0 || spi_cs_n !== 1'b1)
      $display("FAIL reset_idle: got busy=%b cs_n=%b expected 0/1", busy, spi_cs_n);
    else n_pass++;
  endtask

  task automatic test_program(input bit ramp);
    bit ok;
    int bad;
    logic [15:0] exp_crc;
    for (int i = 0; i < 2048; i++) mem[i] = ramp ? 16'(i) : 16'($urandom);
    start_run(16'h000F);
    wait_done(ok);
    n_checks++;
    if (!ok) $display("FAIL prog_done: got addr=%h r0=%h expected %h/%h", mcs_spi_addr, mcs_spi_addr_r0, DONE_ADDR, LAST_ADDR);
    else n_pass++;
    n_checks++;
    if (frames.size() != NFR) $display("FAIL prog_frames: got %0d expected %0d", frames.size(), NFR);
    else n_pass++;
    bad = 0;
    for (int k = 0; k < frames.size() && k < NFR; k++) begin
      if (frames[k] !== mem[k]) begin
        if (bad < 4) $display("FAIL prog_word[%0d]: got %h expected %h", k, frames[k], mem[k]);
        bad++;
      end
    end
    n_checks++;
    if (bad != 0) $display("FAIL prog_words: got %0d bad words expected 0", bad);
    else n_pass++;
    if (ramp && frames.size() > 5) begin
      n_checks++;
      if (frames[5] !== 16'h0005) $display("FAIL prog_frame5: got %h expected 0005", frames[5]);
      else n_pass++;
    end
    if (fr_start.size() >= 2) begin
      n_checks++;
      if (fr_start[1] - fr_start[0] != FRAME_CYC)
        $display("FAIL frame_period: got %0d expected %0d", fr_start[1] - fr_start[0], FRAME_CYC);
      else n_pass++;
    end
    n_checks++;
    if (rb_data.size() != 0) $display("FAIL prog_no_rb: got %0d strobes expected 0", rb_data.size());
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || spi_cs_n !== 1'b1) $display("FAIL prog_end_idle: got busy=%b cs_n=%b expected 0/1", busy, spi_cs_n);
    else n_pass++;
`ifdef MCS_SPI_CRC_EN
    exp_crc = 16'hFFFF;
    for (int k = 0; k < NFR; k++) exp_crc = crc_ref(exp_crc, mem[k]);
`else
    exp_crc = 16'h0000;
`endif
    n_checks++;
    if (crc !== exp_crc) $display("FAIL prog_crc: got %h expected %h", crc, exp_crc);
    else n_pass++;
  endtask

  task automatic test_done_hold();
    repeat (1000) @(negedge clk_25m);
    n_checks++;
    if (fr_start.size() != NFR) $display("FAIL hold_no_restart: got %0d frames expected %0d", fr_start.size(), NFR);
    else n_pass++;
    n_checks++;
    if (mcs_spi_addr !== DONE_ADDR || mcs_spi_addr_r0 !== LAST_ADDR || busy !== 1'b0)
      $display("FAIL hold_signature: got %h/%h busy=%b expected %h/%h busy=0", mcs_spi_addr, mcs_spi_addr_r0, busy, DONE_ADDR, LAST_ADDR);
    else n_pass++;
    @(posedge clk_25m); #1;
    p2040_instruction = 16'h0000;
    repeat (2) @(negedge clk_25m);
    n_checks++;
    if (mcs_spi_addr !== 16'h0 || mcs_spi_addr_r0 !== 16'h0 || busy !== 1'b0)
      $display("FAIL done_exit: got %h/%h busy=%b expected 0000/0000 busy=0", mcs_spi_addr, mcs_spi_addr_r0, busy);
    else n_pass++;
  endtask

  task automatic test_readback();
    bit ok;
    int bad, nz;
    logic [15:0] exp_w;
    logic [15:0] exp_crc;
    start_run(16'h00AA);
    wait_done(ok);
    n_checks++;
    if (!ok) $display("FAIL rb_done: got addr=%h r0=%h expected %h/%h", mcs_spi_addr, mcs_spi_addr_r0, DONE_ADDR, LAST_ADDR);
    else n_pass++;
    n_checks++;
    if (rb_data.size() != NFR) $display("FAIL rb_count: got %0d expected %0d", rb_data.size(), NFR);
    else n_pass++;
    nz = 0;
    foreach (frames[k]) if (frames[k] !== 16'h0) nz++;
    n_checks++;
    if (nz != 0 || frames.size() != NFR) $display("FAIL rb_mosi_zero: got %0d nonzero of %0d expected 0 of %0d", nz, frames.size(), NFR);
    else n_pass++;
    bad = 0;
    for (int k = 0; k < rb_data.size() && k < NFR; k++) begin
      exp_w = ~(16'(2 * k));
      if (rb_data[k] !== exp_w || rb_addr[k] !== 11'(k)) begin
        if (bad < 4) $display("FAIL rb_word[%0d]: got %h@%h expected %h@%h", k, rb_data[k], rb_addr[k], exp_w, 11'(k));
        bad++;
      end
    end
    n_checks++;
    if (bad != 0) $display("FAIL rb_words: got %0d bad expected 0", bad);
    else n_pass++;
    if (rb_data.size() > 8) begin
      n_checks++;
      if (rb_data[8] !== 16'hFFEF) $display("FAIL rb_addr_0010: got %h expected FFEF", rb_data[8]);
      else n_pass++;
    end
`ifdef MCS_SPI_CRC_EN
    exp_crc = 16'hFFFF;
    for (int k = 0; k < NFR; k++) exp_crc = crc_ref(exp_crc, ~(16'(2 * k)));
`else
    exp_crc = 16'h0000;
`endif
    n_checks++;
    if (crc !== exp_crc) $display("FAIL rb_crc: got %h expected %h", crc, exp_crc);
    else n_pass++;
    stop_run();
  endtask

  task automatic test_abort();
    bit seen;
    for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
    start_run(16'h000F);
    seen = 1'b0;
    for (int i = 0; i < 4 * FRAME_CYC + 50; i++) begin
      @(negedge clk_25m);
      if (fr_start.size() >= 3) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) $display("FAIL abort_frame3: got %0d frames expected 3", fr_start.size());
    else n_pass++;
    repeat ($urandom_range(1, 50)) @(posedge clk_25m);
    #1 p2040_instruction = 16'h0000;
    @(posedge clk_25m); #1;
    n_checks++;
    if ({spi_cs_n, spi_sclk, busy, rb_wr_en} !== 4'b1000)
      $display("FAIL abort_bus: got cs_n/sclk/busy/rb=%b expected 1000", {spi_cs_n, spi_sclk, busy, rb_wr_en});
    else n_pass++;
    n_checks++;
    if (mcs_spi_addr !== 16'h0 || mcs_spi_addr_r0 !== 16'h0)
      $display("FAIL abort_addr: got %h/%h expected 0000/0000", mcs_spi_addr, mcs_spi_addr_r0);
    else n_pass++;
    repeat (300) @(negedge clk_25m);
    n_checks++;
    if (fr_start.size() != 3 || frames.size() != 2 || rb_data.size() != 0)
      $display("FAIL abort_quiet: got starts=%0d full=%0d rb=%0d expected 3/2/0", fr_start.size(), frames.size(), rb_data.size());
    else n_pass++;
    test_readback();
  endtask

  task automatic test_toggle();
    bit ok;
    int bad;
    for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
    start_run(16'h000F);
    for (int t = 0; t < 6; t++) begin
      repeat ($urandom_range(40, 250)) @(posedge clk_25m);
      #1 p2040_instruction = (p2040_instruction == 16'h000F) ? 16'h00AA : 16'h000F;
    end
    wait_done(ok);
    n_checks++;
    if (!ok) $display("FAIL toggle_done: got addr=%h r0=%h expected %h/%h", mcs_spi_addr, mcs_spi_addr_r0, DONE_ADDR, LAST_ADDR);
    else n_pass++;
    bad = (frames.size() == NFR) ? 0 : 1;
    for (int k = 0; k < frames.size() && k < NFR; k++) if (frames[k] !== mem[k]) bad++;
    n_checks++;
    if (bad != 0 || rb_data.size() != 0)
      $display("FAIL toggle_mode_kept: got %0d bad frames, %0d strobes expected 0/0", bad, rb_data.size());
    else n_pass++;
    stop_run();
  endtask

  task automatic test_reset_mid_shift();
    bit seen;
    start_run(16'h000F);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_25m);
      if (spi_cs_n == 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) $display("FAIL rstmid_cs_low: got cs_n=%b expected 0", spi_cs_n);
    else n_pass++;
    repeat ($urandom_range(2, 30)) @(posedge clk_25m);
    #5 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({spi_cs_n, spi_sclk, spi_mosi, rb_wr_en, busy} !== 5'b10000 || mcs_spi_addr !== 16'h0 ||
        mcs_spi_addr_r0 !== 16'h0 || buf_rd_addr !== 11'h0 || rb_wr_data !== 16'h0 || crc !== 16'h0)
      $display("FAIL rstmid_outputs: got ctl=%b addr=%h r0=%h crc=%h expected 10000/0000/0000/0000",
               {spi_cs_n, spi_sclk, spi_mosi, rb_wr_en, busy}, mcs_spi_addr, mcs_spi_addr_r0, crc);
    else n_pass++;
    p2040_instruction = 16'h0000;
    repeat (3) @(negedge clk_25m);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_25m);
    n_checks++;
    if (busy !== 1'b0 || spi_cs_n !== 1'b1 || mcs_spi_addr !== 16'h0)
      $display("FAIL rstmid_idle: got busy=%b cs_n=%b addr=%h expected 0/1/0000", busy, spi_cs_n, mcs_spi_addr);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    test_reset();
    test_program(1'b1);
    test_done_hold();
    test_readback();
    test_abort();
    test_program(1'b0);
    stop_run();
    test_toggle();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
